seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Unsigned sequential shift-and-add multiplier: loads two WIDTH-bit operands on a write strobe and forms their 2·WIDTH-bit product one partial-product step per clock. It is the arithmetic core of the sequential binary multiplier and trades area for latency, replacing an array multiplier. It has no busy/done output; the product register is readable at the fixed latency defined below.

## Interface
- WIDTH, default 8: operand width; product width is 2·WIDTH.
- clk  input  1  rising-edge clock; the single clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising clk edge).
- write  input  1  load strobe; when 1 at a clk edge, operands are captured and a new multiplication is armed.
- mul  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- prod  output  2·WIDTH  product register, unsigned.

## Operation
- Registers:
  - M: multiplicand, WIDTH bits.
  - Q: multiplier/low-product, WIDTH bits.
  - A: accumulator, WIDTH+1 bits including carry.
  - cnt: step counter, ceil(log2(WIDTH+1)) bits.
  - state.
  - prod.
- States: IDLE, BUSY, DONE.
- reset=0: state=IDLE; M, Q, A, cnt and prod cleared to 0. Reset has priority over write.
- write=1 (reset=1), any state:
  - M←mul, Q←b, A←0, cnt←WIDTH, prod←0, state←BUSY.
  - A write during BUSY aborts the current operation and restarts.
  - While write stays high, the load repeats every cycle and no step executes.
- BUSY with write=0, one step per cycle:
  - A' = A + (Q[0] ? M : 0), computed in WIDTH+1 bits.
  - {A,Q} ← {A',Q[WIDTH-1:1]}, i.e. {A',Q} shifted right by one.
  - cnt←cnt−1.
- On the step where cnt goes 1→0: prod ← {A'[WIDTH:0],Q[WIDTH-1:1]} (the shifted result's low 2·WIDTH bits), state←DONE.
- DONE and IDLE: all registers hold. prod keeps the last product until the next write or reset.
- Arithmetic:
  - Unsigned, exact; no overflow is possible (max (2^W−1)² < 2^(2W)).
  - Zero operands need no special path.
- mul and b are ignored except on write cycles.

## Timing
- Edge E0 is the last rising edge with write=1. Steps execute on edges E1..E_WIDTH; prod is valid immediately after edge E_WIDTH, i.e. WIDTH cycles after the final write edge.
- prod reads 0 from every write edge until the product appears. There are no intermediate partial values on prod.
- Back-to-back: a write on the edge after DONE is entered starts the next operation with no dead cycle.
- Simultaneous reset=0 and write=1: reset wins; state=IDLE and prod=0.
- Reset mid-BUSY: the operation is discarded and the block stays IDLE until the next write.
- All outputs are registered; there is no combinational path from inputs to prod.

## Structure
- Shared package seq_mul_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Default WIDTH constant.
  - Counter-width function (clog2(WIDTH+1)).
- Top seq_multiplier holds the control FSM, counter and prod register.
- One sub-module, seq_mul_datapath: M/A/Q registers plus the WIDTH+1-bit conditional adder and the right shifter. Control inputs are load and step; output is {A',Q} after the step.

## Test plan
- reset=0 for 1 cycle, then write=1 for 2 cycles with mul=17, b=16, then write=0 → prod=0 until 8 cycles after the last write edge, then prod=272 (0x0110), held stable for ≥5 further cycles.
- mul=255, b=255, single-cycle write → prod=65025 (0xFE01) after 8 cycles. mul=0, b=200 → prod=0. mul=1, b=1 → prod=1.
- Start 13×11; assert write with mul=6, b=7 four cycles later → result 143 never appears; prod=42 eight cycles after the second write.
- Start 100×3; drive reset=0 for one cycle at step 5 → prod=0 and stays 0 with no further writes. A following write of 9×9 → prod=81.
- Drive reset=0 and write=1 on the same edge with mul=5, b=5 → prod=0 and IDLE; no product appears.
- Randomized back-to-back operations (≥200) → each prod equals mul×b exactly WIDTH cycles after its write edge.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t    : control FSM states
//   DEF_WIDTH  : default operand width
//   cnt_width  : bits needed to count WIDTH steps down to zero
package seq_mul_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_mul_if.sv
// Operand/product bus of the sequential multiplier.
//   write : load strobe (captures mul/b, arms a multiplication)
//   mul   : multiplicand, b : multiplier (both unsigned, WIDTH bits)
//   prod  : registered 2*WIDTH-bit product
// master = stimulus side, slave = multiplier side.
interface seq_mul_if
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                   write;
    logic [WIDTH-1:0]       mul;
    logic [WIDTH-1:0]       b;
    logic [2*WIDTH-1:0]     prod;

    modport master (output write, output mul, output b, input prod);
    modport slave  (input write, input mul, input b, output prod);
endinterface

// File: rtl/seq_mul_datapath.sv
// M/A/Q registers with the WIDTH+1-bit conditional adder and right shifter.
//   clk, reset : clock, synchronous active-low reset
//   load       : capture mul/b, clear accumulator
//   step       : one add-and-shift partial-product step
//   mul, b     : operands
//   res        : {A',Q} after the step (low 2*WIDTH bits), i.e. the
//                product once the final step has been taken
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mul,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   res
);
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   a_sum;

    // Extra accumulator bit keeps the carry of the add before the shift.
    assign a_sum = a_q + (q_q[0] ? {1'b0, m_q} : '0);
    // Q[0] has been consumed, so it drops out of the shifted result.
    assign res   = {a_sum, q_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_q <= '0;
            q_q <= '0;
            a_q <= '0;
        end else if (load) begin
            m_q <= mul;
            q_q <= b;
            a_q <= '0;
        end else if (step) begin
            a_q <= {1'b0, a_sum[WIDTH:1]};
            q_q <= {a_sum[0], q_q[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// Unsigned sequential shift-and-add multiplier, one step per clock.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (wins over write)
//   bus   : seq_mul_if slave; prod is valid WIDTH cycles after the last
//           write edge and reads 0 until then, then holds.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    seq_mul_if.slave     bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2*WIDTH-1:0]   prod_q, prod_n;
    logic [2*WIDTH-1:0]   res;
    logic                 load, step;

    seq_mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .mul   (bus.mul),
        .b     (bus.b),
        .res   (res)
    );

    // Write restarts from any state, including mid-operation aborts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        prod_n  = prod_q;
        load    = 1'b0;
        step    = 1'b0;
        if (bus.write) begin
            load    = 1'b1;
            state_n = BUSY;
            cnt_n   = CW'(WIDTH);
            prod_n  = '0;
        end else if (state == BUSY) begin
            step  = 1'b1;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                prod_n  = res;
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            prod_q <= prod_n;
        end
    end

    assign bus.prod = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed scenarios plus random
// back-to-back operations against a cycle-level reference model.
module tb_seq_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference model: product of the last accepted write, published
    // W edges later; cleared by reset or a new write.
    logic [2*W-1:0] m_exp = '0;
    logic [2*W-1:0] m_pend = '0;
    int             m_cnt = 0;

    seq_mul_if #(.WIDTH(W)) bus();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare prod against it 1 time unit after the edge.
    task automatic tick(input string tag);
        logic           r, w;
        logic [W-1:0]   a, bb;
        r = reset; w = bus.write; a = bus.mul; bb = bus.b;
        @(posedge clk);
        if (!r) begin
            m_exp = '0;
            m_cnt = 0;
        end else if (w) begin
            m_exp  = '0;
            m_cnt  = W;
            m_pend = (2*W)'(int'(a) * int'(bb));
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_exp = m_pend;
        end
        #1;
        chk(tag, bus.prod, m_exp);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb,
                          input logic [2*W-1:0] exp, input string tag);
        bus.write = 1'b1; bus.mul = a; bus.b = bb;
        tick("load");
        bus.write = 1'b0; bus.mul = $urandom; bus.b = $urandom;
        for (int i = 0; i < W; i++) tick("step");
        chk(tag, bus.prod, exp);
    endtask

    initial begin
        reset = 1'b0; bus.write = 1'b0; bus.mul = '0; bus.b = '0;
        tick("reset");
        chk("reset_prod", bus.prod, 16'd0);
        reset = 1'b1;

        // Two-cycle write, product 8 cycles after the last write edge.
        bus.write = 1'b1; bus.mul = 8'd17; bus.b = 8'd16;
        tick("wr1");
        tick("wr2");
        bus.write = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            tick("lat");
            chk("lat_zero", bus.prod, 16'd0);
        end
        tick("lat_last");
        chk("p272", bus.prod, 16'd272);
        for (int i = 0; i < 5; i++) begin
            tick("hold");
            chk("hold272", bus.prod, 16'd272);
        end

        run_op(8'd255, 8'd255, 16'd65025, "max");
        run_op(8'd0,   8'd200, 16'd0,     "zero");
        run_op(8'd1,   8'd1,   16'd1,     "one");

        // Abort: second write four cycles into 13x11.
        bus.write = 1'b1; bus.mul = 8'd13; bus.b = 8'd11;
        tick("ab_wr1");
        bus.write = 1'b0;
        for (int i = 0; i < 3; i++) tick("ab_busy");
        bus.write = 1'b1; bus.mul = 8'd6; bus.b = 8'd7;
        tick("ab_wr2");
        bus.write = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick("ab_run");
            checks++;
            assert (bus.prod !== 16'd143) else begin
                errors++;
                $error("FAIL abort_no143 observed=%0d expected=not 143", bus.prod);
            end
            if (i == W - 1) chk("abort42", bus.prod, 16'd42);
        end

        // Reset at step 5 of 100x3.
        bus.write = 1'b1; bus.mul = 8'd100; bus.b = 8'd3;
        tick("rs_wr");
        bus.write = 1'b0;
        for (int i = 0; i < 4; i++) tick("rs_busy");
        reset = 1'b0;
        tick("rs_mid");
        reset = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            tick("rs_idle");
            chk("rs_zero", bus.prod, 16'd0);
        end
        run_op(8'd9, 8'd9, 16'd81, "after_rst");

        // Reset and write on the same edge: reset wins.
        reset = 1'b0; bus.write = 1'b1; bus.mul = 8'd5; bus.b = 8'd5;
        tick("rw_same");
        chk("rw_zero", bus.prod, 16'd0);
        reset = 1'b1; bus.write = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick("rw_idle");
            chk("rw_noprod", bus.prod, 16'd0);
        end

        // Random operations, mostly back-to-back.
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] a, bb;
            int gap;
            a  = W'($urandom);
            bb = W'($urandom);
            run_op(a, bb, (2*W)'(int'(a) * int'(bb)), "rand");
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g < gap; g++) tick("rand_gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
